snf_rr_entry_sel: RTL and testbench
===================================

# snf_rr_entry_sel

Parametrised round-robin entry selector for the SNF request queue, used by snf_qos to choose the next entry to issue. It registers a request vector on each update strobe. It then picks one entry from two priority classes (high/low), each with its own wrap-around round-robin pointer. An optional starvation guard forces a low-class grant after a run of consecutive high-class grants.

## Interface
- ENTRIES_NUM, 16, number of queue entries (>=2, need not be a power of 2)
- ENTRY_IDX_W, 4, index width; must satisfy 2^ENTRY_IDX_W >= ENTRIES_NUM
- STARVE_TH, 8, consecutive high-class grants tolerated while low-class requests pend (1..255)

- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_entry_vec  input  ENTRIES_NUM  per-entry request from snf_qos
- req_entry_hi_vec  input  ENTRIES_NUM  per-entry high-class flag (only meaningful where req_entry_vec=1)
- upd_start_entry  input  1  capture strobe: snapshot requests, advance pointers
- req_entry_ptr_sel  output  ENTRIES_NUM  one-hot selected entry, 0 when none
- req_entry_ptr_idx  output  ENTRY_IDX_W  binary index of selected entry, 0 when none
- sel_valid  output  1  a selection exists
- sel_hi  output  1  selection came from high class

## Operation
- State: req_q and hi_q (snapshots), ptr_hi and ptr_lo (ENTRY_IDX_W each, range 0..ENTRIES_NUM-1), starve_cnt (8 bits).
- On upd_start_entry=1, req_q<=req_entry_vec and hi_q<=req_entry_vec&req_entry_hi_vec. With upd_start_entry=0, all state holds.
- Class vectors: vh=req_q&hi_q and vl=req_q&~hi_q.
- Per class, the selection is the lowest set bit with index >= ptr. If none exists, it wraps to the lowest set bit overall. This is a combinational function of the registered state only.
- Class choice:
  - Only vl!=0: low class.
  - Only vh!=0: high class.
  - Both nonzero: high class, unless the starvation override is active (see Configuration).
  - Neither: sel_valid=0 and both selection outputs are 0.
- On the same upd_start_entry edge, if sel_valid=1, the winning class pointer advances to (selected index+1), wrapping to 0 when the result equals ENTRIES_NUM. The losing class pointer holds.
- Arithmetic: the pointer increment is compared against ENTRIES_NUM explicitly, not by power-of-2 truncation. req_entry_ptr_idx always agrees with req_entry_ptr_sel.

## Timing
- Latency: req_entry_vec sampled at edge N (with strobe) drives the outputs from edge N onward, i.e. one register stage.
- Pointer and starve_cnt updates at edge N use the selection from the pre-edge snapshot (the one consumed at edge N).
- Outputs stay stable between strobes. Back-to-back strobes are legal every cycle.
- Reset values: all outputs 0, req_q=hi_q=0, ptr_hi=ptr_lo=0, starve_cnt=0.
- Reset mid-operation: asynchronous clear of all state. The first strobe after deassertion behaves as the first after power-up.
- A pointer pointing at a non-requesting entry is legal; the search starts there and wraps.

## Configuration
- SNF_RR_STARVE_EN defined:
  - On each strobe with sel_valid=1, starve_cnt increments (saturating at 255) when the high class wins while vl!=0. It clears whenever the low class wins or vl=0.
  - When starve_cnt>=STARVE_TH and both classes request, the low class wins.
- Undefined:
  - Strict priority: high always wins. starve_cnt is not implemented and the override never happens.

## Test plan
- Reset/empty: hold rst_n=0, then release, then strobe with req_entry_vec=0 -> sel_valid=0, sel=0, idx=0, pointers stay 0.
- Round-robin wrap (ENTRIES_NUM=4): req=4'b1011, hi=0, strobe every cycle -> idx sequence 0,1,3,0,1; ptr_lo after each grant: 1,2,0,1,2.
- Non-power-of-2 wrap (ENTRIES_NUM=5): req=5'b10001, hi=0, repeated strobes -> idx 0,4,0,4; ptr_lo goes 1,0,1,0 (5 wraps to 0).
- Priority and independent pointers (ENTRIES_NUM=4): req=4'b1111, hi=4'b0101 -> high grants idx 0,2,0 with ptr_lo held at 0; then hi=0 -> low grants start at idx 0.
- Starvation (SNF_RR_STARVE_EN, STARVE_TH=2, ENTRIES_NUM=4): req=4'b1111, hi=4'b0011, strobes -> idx 0,1,2 (low, sel_hi=0),0,1,3; starve_cnt 1,2,0,1,2,0. Without the macro -> idx 0,1,0,1,... and sel_hi stays 1.
- Async reset mid-stream: assert rst_n between clock edges during the sequence above -> outputs go to 0 immediately. After release, req=4'b1011 then strobe -> idx=0.

Source files
------------

// File: rtl/snf_rr_entry_sel.sv
// Two-class (high/low) round-robin entry selector for the SNF request queue.
// Optional starvation guard: define SNF_RR_STARVE_EN to force a low-class grant after STARVE_TH.
module snf_rr_entry_sel #(
  parameter int unsigned ENTRIES_NUM = 16,
  parameter int unsigned ENTRY_IDX_W = 4,
  parameter int unsigned STARVE_TH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ENTRIES_NUM-1:0] req_entry_vec,
  input  logic [ENTRIES_NUM-1:0] req_entry_hi_vec,
  input  logic                   upd_start_entry,
  output logic [ENTRIES_NUM-1:0] req_entry_ptr_sel,
  output logic [ENTRY_IDX_W-1:0] req_entry_ptr_idx,
  output logic                   sel_valid,
  output logic                   sel_hi
);

  if ((ENTRIES_NUM < 2) || (ENTRIES_NUM > (1 << ENTRY_IDX_W)) ||
      (STARVE_TH < 1) || (STARVE_TH > 255)) begin : g_param_err
    $error("snf_rr_entry_sel: illegal parameter combination");
  end

  localparam logic [ENTRY_IDX_W:0] PtrWrap = ENTRIES_NUM[ENTRY_IDX_W:0];
  localparam logic [ENTRY_IDX_W:0] PtrOne  = {{ENTRY_IDX_W{1'b0}}, 1'b1};

  logic [ENTRIES_NUM-1:0] req_q, req_d;
  logic [ENTRIES_NUM-1:0] hi_q, hi_d;
  logic [ENTRY_IDX_W-1:0] ptr_hi, ptr_hi_d;
  logic [ENTRY_IDX_W-1:0] ptr_lo, ptr_lo_d;

  logic [ENTRIES_NUM-1:0] vh, vl;
  logic                   hi_any, lo_any;
  logic [ENTRY_IDX_W-1:0] hi_pick, lo_pick;
  logic                   grant_hi, grant_lo;
  logic                   starve_ovr;

  function automatic logic [ENTRY_IDX_W-1:0] first_idx(input logic [ENTRIES_NUM-1:0] v);
    logic [ENTRY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(ENTRIES_NUM) - 1; i >= 0; i--) begin
      if (v[i]) idx = ENTRY_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [ENTRIES_NUM-1:0] ge_mask(input logic [ENTRY_IDX_W-1:0] ptr);
    logic [ENTRIES_NUM-1:0] m;
    for (int unsigned i = 0; i < ENTRIES_NUM; i++) begin
      m[i] = (ENTRY_IDX_W'(i) >= ptr);
    end
    return m;
  endfunction

  // Lowest requester at or above ptr, otherwise wrap to the lowest requester overall.
  function automatic logic [ENTRY_IDX_W-1:0] rr_pick(input logic [ENTRIES_NUM-1:0] v,
                                                     input logic [ENTRY_IDX_W-1:0] ptr);
    logic [ENTRIES_NUM-1:0] upper;
    upper = v & ge_mask(ptr);
    return (|upper) ? first_idx(upper) : first_idx(v);
  endfunction

  // Explicit compare against ENTRIES_NUM so non-power-of-2 queues wrap correctly.
  function automatic logic [ENTRY_IDX_W-1:0] ptr_after(input logic [ENTRY_IDX_W-1:0] idx);
    logic [ENTRY_IDX_W:0] inc;
    inc = {1'b0, idx} + PtrOne;
    return (inc == PtrWrap) ? '0 : inc[ENTRY_IDX_W-1:0];
  endfunction

  always_comb begin
    vh      = req_q & hi_q;
    vl      = req_q & ~hi_q;
    hi_any  = |vh;
    lo_any  = |vl;
    hi_pick = rr_pick(vh, ptr_hi);
    lo_pick = rr_pick(vl, ptr_lo);
  end

  always_comb begin
    grant_hi = hi_any & (~lo_any | ~starve_ovr);
    grant_lo = lo_any & ~grant_hi;
    sel_valid = hi_any | lo_any;
    sel_hi    = grant_hi;
    req_entry_ptr_idx = '0;
    if (grant_hi) begin
      req_entry_ptr_idx = hi_pick;
    end else if (grant_lo) begin
      req_entry_ptr_idx = lo_pick;
    end
  end

  // One-hot is decoded from the index so the two outputs can never disagree.
  always_comb begin
    req_entry_ptr_sel = '0;
    for (int unsigned i = 0; i < ENTRIES_NUM; i++) begin
      req_entry_ptr_sel[i] = sel_valid && (req_entry_ptr_idx == ENTRY_IDX_W'(i));
    end
  end

  always_comb begin
    req_d    = req_q;
    hi_d     = hi_q;
    ptr_hi_d = ptr_hi;
    ptr_lo_d = ptr_lo;
    if (upd_start_entry) begin
      req_d = req_entry_vec;
      hi_d  = req_entry_vec & req_entry_hi_vec;
      if (grant_hi) ptr_hi_d = ptr_after(hi_pick);
      if (grant_lo) ptr_lo_d = ptr_after(lo_pick);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      hi_q   <= '0;
      ptr_hi <= '0;
      ptr_lo <= '0;
    end else begin
      req_q  <= req_d;
      hi_q   <= hi_d;
      ptr_hi <= ptr_hi_d;
      ptr_lo <= ptr_lo_d;
    end
  end

`ifdef SNF_RR_STARVE_EN
  localparam logic [7:0] StarveTh = STARVE_TH[7:0];

  logic [7:0] starve_cnt, starve_cnt_d;

  assign starve_ovr = (starve_cnt >= StarveTh);

  // Counts high-class wins that bypassed pending low-class requests.
  always_comb begin
    starve_cnt_d = starve_cnt;
    if (upd_start_entry) begin
      if (grant_hi && lo_any) begin
        starve_cnt_d = (starve_cnt == 8'hff) ? starve_cnt : starve_cnt + 8'd1;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_d;
    end
  end
`else
  assign starve_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_snf_rr_entry_sel.sv
// Directed bench for snf_rr_entry_sel: reset, RR wrap (4/5/16 entries), priority,
// starvation guard (SNF_RR_STARVE_EN aware) and asynchronous mid-stream reset.
module tb_snf_rr_entry_sel;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  req_a, hi_a, sel_a;
  logic [1:0]  idx_a;
  logic        upd_a, vld_a, shi_a;
  logic [4:0]  req_b, hi_b, sel_b;
  logic [2:0]  idx_b;
  logic        upd_b, vld_b, shi_b;
  logic [3:0]  req_c, hi_c, sel_c;
  logic [1:0]  idx_c;
  logic        upd_c, vld_c, shi_c;
  logic [15:0] req_d, hi_d, sel_d;
  logic [3:0]  idx_d;
  logic        upd_d, vld_d, shi_d;

  snf_rr_entry_sel #(.ENTRIES_NUM(4), .ENTRY_IDX_W(2), .STARVE_TH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_entry_vec(req_a), .req_entry_hi_vec(hi_a),
    .upd_start_entry(upd_a), .req_entry_ptr_sel(sel_a), .req_entry_ptr_idx(idx_a),
    .sel_valid(vld_a), .sel_hi(shi_a)
  );
  snf_rr_entry_sel #(.ENTRIES_NUM(5), .ENTRY_IDX_W(3), .STARVE_TH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_entry_vec(req_b), .req_entry_hi_vec(hi_b),
    .upd_start_entry(upd_b), .req_entry_ptr_sel(sel_b), .req_entry_ptr_idx(idx_b),
    .sel_valid(vld_b), .sel_hi(shi_b)
  );
  snf_rr_entry_sel #(.ENTRIES_NUM(4), .ENTRY_IDX_W(2), .STARVE_TH(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_entry_vec(req_c), .req_entry_hi_vec(hi_c),
    .upd_start_entry(upd_c), .req_entry_ptr_sel(sel_c), .req_entry_ptr_idx(idx_c),
    .sel_valid(vld_c), .sel_hi(shi_c)
  );
  snf_rr_entry_sel #(.ENTRIES_NUM(16), .ENTRY_IDX_W(4), .STARVE_TH(8)) dut_d (
    .clk(clk), .rst_n(rst_n), .req_entry_vec(req_d), .req_entry_hi_vec(hi_d),
    .upd_start_entry(upd_d), .req_entry_ptr_sel(sel_d), .req_entry_ptr_idx(idx_d),
    .sel_valid(vld_d), .sel_hi(shi_d)
  );

  // Hand-derived expectations, indexed by strobe edge.
  int rr4_idx[6] = '{0, 1, 3, 0, 1, 3};
  int rr4_ptr[6] = '{0, 1, 2, 0, 1, 2};
  int rr5_idx[5] = '{0, 4, 0, 4, 0};
  int rr5_ptr[5] = '{0, 1, 0, 1, 0};
  int rr16_idx[3] = '{3, 15, 3};
  int rr16_ptr[3] = '{0, 4, 0};
  int pri_idx[3] = '{0, 2, 0};
`ifdef SNF_RR_STARVE_EN
  int stv_idx[7] = '{0, 1, 2, 0, 1, 3, 0};
  int stv_hi[7]  = '{1, 1, 0, 1, 1, 0, 1};
  int stv_cnt[7] = '{0, 1, 2, 0, 1, 2, 0};
`else
  int stv_idx[7] = '{0, 1, 0, 1, 0, 1, 0};
  int stv_hi[7]  = '{1, 1, 1, 1, 1, 1, 1};
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0; hi_a = '0; upd_a = 1'b0;
    req_b = '0; hi_b = '0; upd_b = 1'b0;
    req_c = '0; hi_c = '0; upd_c = 1'b0;
    req_d = '0; hi_d = '0; upd_d = 1'b0;

    // Reset / empty
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld_a", 32'(vld_a), 32'd0);
    check("rst_sel_a", 32'(sel_a), 32'd0);
    check("rst_idx_a", 32'(idx_a), 32'd0);
    check("rst_shi_c", 32'(shi_c), 32'd0);
    check("rst_vld_d", 32'(vld_d), 32'd0);
    #2 rst_n = 1'b1;
    upd_a = 1'b1; upd_b = 1'b1; upd_c = 1'b1; upd_d = 1'b1;
    tick();
    check("empty_vld_a", 32'(vld_a), 32'd0);
    check("empty_sel_a", 32'(sel_a), 32'd0);
    check("empty_idx_a", 32'(idx_a), 32'd0);
    check("empty_ptr_lo_a", 32'(dut_a.ptr_lo), 32'd0);
    check("empty_ptr_hi_a", 32'(dut_a.ptr_hi), 32'd0);
    check("empty_vld_b", 32'(vld_b), 32'd0);
    upd_a = 1'b0; upd_b = 1'b0; upd_c = 1'b0; upd_d = 1'b0;

    // Round-robin wrap, 4 entries
    req_a = 4'b1011; hi_a = 4'b0000; upd_a = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rr4_idx%0d", k), 32'(idx_a), 32'(rr4_idx[k]));
      check($sformatf("rr4_sel%0d", k), 32'(sel_a), 32'd1 << rr4_idx[k]);
      check($sformatf("rr4_ptr%0d", k), 32'(dut_a.ptr_lo), 32'(rr4_ptr[k]));
    end
    // Strobe low: new request vector must be ignored
    upd_a = 1'b0; req_a = 4'b0100;
    tick();
    check("hold_idx_a", 32'(idx_a), 32'd3);
    check("hold_vld_a", 32'(vld_a), 32'd1);
    check("hold_ptr_a", 32'(dut_a.ptr_lo), 32'd2);

    // Non-power-of-2 wrap, 5 entries
    req_b = 5'b10001; upd_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr5_idx%0d", k), 32'(idx_b), 32'(rr5_idx[k]));
      check($sformatf("rr5_sel%0d", k), 32'(sel_b), 32'd1 << rr5_idx[k]);
      check($sformatf("rr5_ptr%0d", k), 32'(dut_b.ptr_lo), 32'(rr5_ptr[k]));
    end
    upd_b = 1'b0;

    // Full-width wrap, 16 entries (15+1 must become 0)
    req_d = 16'h8008; upd_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rr16_idx%0d", k), 32'(idx_d), 32'(rr16_idx[k]));
      check($sformatf("rr16_sel%0d", k), 32'(sel_d), 32'd1 << rr16_idx[k]);
      check($sformatf("rr16_ptr%0d", k), 32'(dut_d.ptr_lo), 32'(rr16_ptr[k]));
    end
    upd_d = 1'b0;

    // Asynchronous reset pulse between edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld_d", 32'(vld_d), 32'd0);
    check("arst_idx_d", 32'(idx_d), 32'd0);
    check("arst_vld_a", 32'(vld_a), 32'd0);
    #3 rst_n = 1'b1;

    // Priority with independent pointers
    req_a = 4'b1111; hi_a = 4'b0101; upd_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("pri_idx%0d", k), 32'(idx_a), 32'(pri_idx[k]));
      check($sformatf("pri_shi%0d", k), 32'(shi_a), 32'd1);
      check($sformatf("pri_ptr_lo%0d", k), 32'(dut_a.ptr_lo), 32'd0);
    end
    hi_a = 4'b0000;
    tick();
    check("pri_lo_idx0", 32'(idx_a), 32'd0);
    check("pri_lo_shi0", 32'(shi_a), 32'd0);
    check("pri_lo_ptr_hi", 32'(dut_a.ptr_hi), 32'd1);
    tick();
    check("pri_lo_idx1", 32'(idx_a), 32'd1);
    check("pri_lo_ptr_lo", 32'(dut_a.ptr_lo), 32'd1);
    upd_a = 1'b0;

    // Starvation guard (or strict priority without the macro)
    req_c = 4'b1111; hi_c = 4'b0011; upd_c = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("stv_idx%0d", k), 32'(idx_c), 32'(stv_idx[k]));
      check($sformatf("stv_shi%0d", k), 32'(shi_c), 32'(stv_hi[k]));
`ifdef SNF_RR_STARVE_EN
      check($sformatf("stv_cnt%0d", k), 32'(dut_c.starve_cnt), 32'(stv_cnt[k]));
`endif
    end

    // Mid-stream asynchronous reset, strobe kept high throughout
    #2 rst_n = 1'b0;
    #1;
    check("mid_vld_c", 32'(vld_c), 32'd0);
    check("mid_sel_c", 32'(sel_c), 32'd0);
    check("mid_idx_c", 32'(idx_c), 32'd0);
    check("mid_shi_c", 32'(shi_c), 32'd0);
    req_c = 4'b1011; hi_c = 4'b0000;
    tick();
    check("mid_held_vld_c", 32'(vld_c), 32'd0);
`ifdef SNF_RR_STARVE_EN
    check("mid_cnt_c", 32'(dut_c.starve_cnt), 32'd0);
`endif
    #3 rst_n = 1'b1;
    tick();
    check("post_idx_c", 32'(idx_c), 32'd0);
    check("post_sel_c", 32'(sel_c), 32'd1);
    check("post_vld_c", 32'(vld_c), 32'd1);
    check("post_shi_c", 32'(shi_c), 32'd0);
    tick();
    check("post_idx2_c", 32'(idx_c), 32'd1);
    check("post_ptr_c", 32'(dut_c.ptr_lo), 32'd1);
    upd_c = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
